// File: rtl/updown_step_counter.sv
// Up/down counter with programmable step, wrap or saturate arithmetic and a four-phase
// req/ack handshake per direction. Define UPDOWN_STEP_COUNTER_MATCH_EN to add the match compare.
module updown_step_counter #(
    parameter int unsigned     SIZE        = 8,
    parameter int unsigned     STEP_WIDTH  = 4,
    parameter int unsigned     SATURATE    = 0,
    parameter logic [SIZE-1:0] RESET_VALUE = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  up,
    input  logic                  down,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic                  load,
    input  logic [SIZE-1:0]       data,
    output logic                  upAck,
    output logic                  downAck,
    output logic [SIZE-1:0]       counter,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  error
`ifdef UPDOWN_STEP_COUNTER_MATCH_EN
    ,
    input  logic [SIZE-1:0]       matchValue,
    output logic                  match
`endif
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StUpAck   = 2'b01,
        StDownAck = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] counter_q, counter_d;
    logic            up_ack_q, up_ack_d;
    logic            down_ack_q, down_ack_d;
    logic            overflow_q, overflow_d;
    logic            underflow_q, underflow_d;
    logic            error_q, error_d;

    logic [SIZE-1:0] step_ext;
    logic [SIZE:0]   sum;
    logic [SIZE:0]   diff;

    always_comb begin
        step_ext                 = '0;
        step_ext[STEP_WIDTH-1:0] = step;
        // Top bit of the SIZE+1 result is the carry (sum) or borrow (diff).
        sum  = {1'b0, counter_q} + {1'b0, step_ext};
        diff = {1'b0, counter_q} - {1'b0, step_ext};

        state_d     = state_q;
        counter_d   = counter_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        error_d     = error_q;

        case (state_q)
            StIdle: begin
                if (up && down) begin
                    error_d = 1'b1;
                end else if (up && !load) begin
                    state_d   = StUpAck;
                    counter_d = sum[SIZE-1:0];
                    if (sum[SIZE]) begin
                        overflow_d = 1'b1;
                        if (SATURATE != 0) counter_d = '1;
                    end
                end else if (down && !load) begin
                    state_d   = StDownAck;
                    counter_d = diff[SIZE-1:0];
                    if (diff[SIZE]) begin
                        underflow_d = 1'b1;
                        if (SATURATE != 0) counter_d = '0;
                    end
                end
            end
            StUpAck: begin
                if (!up) state_d = StIdle;
            end
            StDownAck: begin
                if (!down) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Load overrides the count but leaves the handshake alone.
        if (load) counter_d = data;

        up_ack_d   = (state_d == StUpAck);
        down_ack_d = (state_d == StDownAck);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            counter_q   <= RESET_VALUE;
            up_ack_q    <= 1'b0;
            down_ack_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            up_ack_q    <= up_ack_d;
            down_ack_q  <= down_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            error_q     <= error_d;
        end
    end

    assign upAck     = up_ack_q;
    assign downAck   = down_ack_q;
    assign counter   = counter_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign error     = error_q;

`ifdef UPDOWN_STEP_COUNTER_MATCH_EN
    logic match_q, match_d;

    always_comb begin
        match_d = (counter_d == matchValue);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`endif

endmodule

// File: tb/tb_updown_step_counter.sv
// Scoreboard bench: stimulus pushes the expected post-edge outputs, a monitor pops and compares.
// Drives a wrap instance (RESET_VALUE 8'h10) and a saturate instance with the same inputs.
module tb_updown_step_counter;

    logic       clk;
    logic       rst;
    logic       up;
    logic       down;
    logic [3:0] step;
    logic       load;
    logic [7:0] data;
    logic [7:0] match_value;

    logic       a_uack, a_dack, a_ovf, a_unf, a_err, a_match;
    logic [7:0] a_cnt;
    logic       b_uack, b_dack, b_ovf, b_unf, b_err, b_match;
    logic [7:0] b_cnt;

    updown_step_counter #(
        .SIZE(8), .STEP_WIDTH(4), .SATURATE(0), .RESET_VALUE(8'h10)
    ) u_wrap (
        .clock(clk), .reset(rst), .up(up), .down(down), .step(step), .load(load), .data(data),
        .upAck(a_uack), .downAck(a_dack), .counter(a_cnt), .overflow(a_ovf),
        .underflow(a_unf), .error(a_err)
`ifdef UPDOWN_STEP_COUNTER_MATCH_EN
        , .matchValue(match_value), .match(a_match)
`endif
    );

    updown_step_counter #(
        .SIZE(8), .STEP_WIDTH(4), .SATURATE(1), .RESET_VALUE(8'h00)
    ) u_sat (
        .clock(clk), .reset(rst), .up(up), .down(down), .step(step), .load(load), .data(data),
        .upAck(b_uack), .downAck(b_dack), .counter(b_cnt), .overflow(b_ovf),
        .underflow(b_unf), .error(b_err)
`ifdef UPDOWN_STEP_COUNTER_MATCH_EN
        , .matchValue(match_value), .match(b_match)
`endif
    );

`ifndef UPDOWN_STEP_COUNTER_MATCH_EN
    assign a_match = 1'b0;
    assign b_match = 1'b0;
`endif

    typedef struct {
        logic       sel;
        logic [7:0] cnt;
        logic       ua, da, ov, un, er;
        logic       chk_m, m;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic m_chk      = 1'b0;
    logic m_exp      = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input logic r, input logic u, input logic d, input logic [3:0] s,
                       input logic l, input logic [7:0] dt, input logic sel,
                       input logic [7:0] c, input logic ua, input logic da, input logic ov,
                       input logic un, input logic er, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r; up = u; down = d; step = s; load = l; data = dt;
        e.sel = sel; e.cnt = c; e.ua = ua; e.da = da; e.ov = ov; e.un = un; e.er = er;
        e.chk_m = m_chk; e.m = m_exp; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge presents a new output set; compare the oldest expectation.
    always @(posedge clk) begin
        exp_t       e;
        logic [7:0] c;
        logic       ua, da, ov, un, er, m;
        logic       bad;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.sel) begin
                c = b_cnt; ua = b_uack; da = b_dack; ov = b_ovf; un = b_unf; er = b_err;
                m = b_match;
            end else begin
                c = a_cnt; ua = a_uack; da = a_dack; ov = a_ovf; un = a_unf; er = a_err;
                m = a_match;
            end
            bad = (c !== e.cnt) || (ua !== e.ua) || (da !== e.da) || (ov !== e.ov) ||
                  (un !== e.un) || (er !== e.er);
`ifdef UPDOWN_STEP_COUNTER_MATCH_EN
            if (e.chk_m && (m !== e.m)) bad = 1'b1;
`endif
            compared++;
            if (bad) begin
                mismatched++;
                $display("FAIL %s: got cnt=%h ua=%b da=%b ov=%b un=%b er=%b m=%b, expected cnt=%h ua=%b da=%b ov=%b un=%b er=%b m=%b",
                         e.name, c, ua, da, ov, un, er, m,
                         e.cnt, e.ua, e.da, e.ov, e.un, e.er, e.m);
            end
        end
    end

    initial begin
        rst = 1'b1; up = 1'b0; down = 1'b0; step = 4'h0; load = 1'b0; data = 8'h00;
        match_value = 8'h07;

        //  rst up dn step ld data sel cnt    ua da ov un er
        cyc(1, 0, 0, 4'h0, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 0, "rst_value");
        cyc(0, 0, 0, 4'h0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, "rst_value_sat");
        cyc(0, 1, 0, 4'h1, 0, 8'h00, 0, 8'h11, 1, 0, 0, 0, 0, "up_accept");
        cyc(1, 1, 0, 4'h1, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 0, "rst_mid_ack");
        cyc(0, 1, 0, 4'h1, 0, 8'h00, 0, 8'h11, 1, 0, 0, 0, 0, "held_after_rst");
        cyc(0, 0, 0, 4'h1, 0, 8'h00, 0, 8'h11, 0, 0, 0, 0, 0, "up_release");

        // Wrap overflow and underflow.
        cyc(1, 0, 0, 4'h0, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 0, "wrap_rst");
        cyc(0, 0, 0, 4'h0, 1, 8'hFE, 0, 8'hFE, 0, 0, 0, 0, 0, "wrap_load_fe");
        cyc(0, 1, 0, 4'h3, 0, 8'h00, 0, 8'h01, 1, 0, 1, 0, 0, "wrap_ovf");
        cyc(0, 1, 0, 4'h3, 0, 8'h00, 0, 8'h01, 1, 0, 0, 0, 0, "wrap_ack_hold");
        cyc(0, 0, 0, 4'h3, 0, 8'h00, 0, 8'h01, 0, 0, 0, 0, 0, "wrap_ack_drop");
        cyc(0, 0, 0, 4'h3, 0, 8'h00, 0, 8'h01, 0, 0, 0, 0, 0, "wrap_idle");
        cyc(0, 0, 0, 4'h0, 1, 8'h02, 0, 8'h02, 0, 0, 0, 0, 0, "wrap_load_02");
        cyc(0, 0, 1, 4'h5, 0, 8'h00, 0, 8'hFD, 0, 1, 0, 1, 0, "wrap_unf");
        cyc(0, 0, 0, 4'h5, 0, 8'h00, 0, 8'hFD, 0, 0, 0, 0, 0, "wrap_unf_drop");

        // Saturate instance.
        cyc(1, 0, 0, 4'h0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, "sat_rst");
        cyc(0, 0, 0, 4'h0, 1, 8'h02, 1, 8'h02, 0, 0, 0, 0, 0, "sat_load_02");
        cyc(0, 0, 1, 4'h5, 0, 8'h00, 1, 8'h00, 0, 1, 0, 1, 0, "sat_unf_clamp");
        cyc(0, 0, 0, 4'h5, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, "sat_unf_drop");
        cyc(0, 0, 0, 4'h0, 1, 8'h05, 1, 8'h05, 0, 0, 0, 0, 0, "sat_load_05");
        cyc(0, 0, 1, 4'h5, 0, 8'h00, 1, 8'h00, 0, 1, 0, 0, 0, "sat_exact_zero");
        cyc(0, 0, 0, 4'h5, 0, 8'h00, 1, 8'h00, 0, 0, 0, 0, 0, "sat_exact_drop");
        cyc(0, 0, 0, 4'h0, 1, 8'hFE, 1, 8'hFE, 0, 0, 0, 0, 0, "sat_load_fe");
        cyc(0, 1, 0, 4'h3, 0, 8'h00, 1, 8'hFF, 1, 0, 1, 0, 0, "sat_ovf_clamp");
        cyc(0, 0, 0, 4'h3, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 0, 0, "sat_ovf_drop");
        cyc(0, 0, 0, 4'h0, 1, 8'hFC, 1, 8'hFC, 0, 0, 0, 0, 0, "sat_load_fc");
        cyc(0, 1, 0, 4'h3, 0, 8'h00, 1, 8'hFF, 1, 0, 0, 0, 0, "sat_exact_max");
        cyc(0, 0, 0, 4'h3, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 0, 0, "sat_max_drop");

        // Protocol error is sticky until reset.
        cyc(1, 0, 0, 4'h1, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 0, "err_rst");
        cyc(0, 1, 1, 4'h1, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 1, "err_both_1");
        cyc(0, 1, 1, 4'h1, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 1, "err_both_2");
        cyc(0, 1, 1, 4'h1, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 1, "err_both_3");
        cyc(0, 0, 0, 4'h1, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 1, "err_sticky");
        cyc(0, 1, 0, 4'h1, 0, 8'h00, 0, 8'h11, 1, 0, 0, 0, 1, "err_count_on");
        cyc(0, 0, 0, 4'h1, 0, 8'h00, 0, 8'h11, 0, 0, 0, 0, 1, "err_still");
        cyc(1, 0, 0, 4'h1, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 0, "err_cleared");

        // Load interaction with requests.
        cyc(0, 1, 0, 4'h2, 1, 8'hA5, 0, 8'hA5, 0, 0, 0, 0, 0, "load_blocks_up");
        cyc(0, 1, 0, 4'h2, 0, 8'hA5, 0, 8'hA7, 1, 0, 0, 0, 0, "up_after_load");
        cyc(0, 0, 0, 4'h2, 0, 8'hA5, 0, 8'hA7, 0, 0, 0, 0, 0, "up_after_drop");
        cyc(0, 0, 1, 4'h1, 0, 8'h00, 0, 8'hA6, 0, 1, 0, 0, 0, "down_accept");
        cyc(0, 0, 1, 4'h1, 1, 8'h3C, 0, 8'h3C, 0, 1, 0, 0, 0, "load_in_dack");
        cyc(0, 0, 1, 4'h1, 0, 8'h3C, 0, 8'h3C, 0, 1, 0, 0, 0, "dack_held");
        cyc(0, 0, 0, 4'h1, 0, 8'h3C, 0, 8'h3C, 0, 0, 0, 0, 0, "dack_drop");
        cyc(0, 1, 0, 4'h0, 0, 8'h00, 0, 8'h3C, 1, 0, 0, 0, 0, "step_zero");
        cyc(0, 0, 0, 4'h0, 0, 8'h00, 0, 8'h3C, 0, 0, 0, 0, 0, "step_zero_drop");

        // Match compare against 8'h07 (only checked when the feature is built in).
        m_chk = 1'b1; m_exp = 1'b0;
        cyc(1, 0, 0, 4'h0, 0, 8'h00, 0, 8'h10, 0, 0, 0, 0, 0, "match_rst");
        cyc(0, 0, 0, 4'h0, 1, 8'h04, 0, 8'h04, 0, 0, 0, 0, 0, "match_load");
        m_exp = 1'b1;
        cyc(0, 1, 0, 4'h3, 0, 8'h00, 0, 8'h07, 1, 0, 0, 0, 0, "match_hit");
        cyc(0, 0, 0, 4'h3, 0, 8'h00, 0, 8'h07, 0, 0, 0, 0, 0, "match_hold");
        cyc(0, 1, 0, 4'h0, 0, 8'h00, 0, 8'h07, 1, 0, 0, 0, 0, "match_step0");
        cyc(0, 0, 0, 4'h0, 0, 8'h00, 0, 8'h07, 0, 0, 0, 0, 0, "match_step0_drop");
        m_chk = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/updown_step_counter.md
Name: updown_step_counter

Overview:
Parametrised successor to the single-step up/down counter. It counts up or down by a programmable step, in either wrap or saturate mode. A full four-phase request/acknowledge handshake runs per direction. The block flags overflow, underflow and protocol errors, and serves as the general counting element between FIFO-side producers and consumers in the BASYS2 designs.

Parameters:
SIZE, 8, counter width in bits (>=2)
STEP_WIDTH, 4, width of step input (1..SIZE); step zero-extended to SIZE
SATURATE, 0, 0 = modulo-2^SIZE wrap, 1 = clamp at 0 / 2^SIZE-1
RESET_VALUE, 0, counter value after reset (SIZE bits)

Ports:
clock  input  1  sole clock; all state changes on posedge
reset  input  1  synchronous, active-high; sampled on posedge clock
up  input  1  increment request, held high until upAck seen
down  input  1  decrement request, held high until downAck seen
step  input  STEP_WIDTH  step amount, sampled on the accepting edge
load  input  1  synchronous load of data
data  input  SIZE  load value
upAck  output  1  high in UP_ACK state
downAck  output  1  high in DOWN_ACK state
counter  output  SIZE  current count (registered)
overflow  output  1  one-cycle pulse: increment carried past 2^SIZE-1
underflow  output  1  one-cycle pulse: decrement borrowed below 0
error  output  1  sticky: up and down both high while IDLE; cleared only by reset

Behaviour:
- Reset (synchronous, highest priority): counter=RESET_VALUE, state=IDLE, upAck=downAck=overflow=underflow=error=0. Reset mid-handshake abandons it; a requester still holding up/down after reset is accepted as a new request on the next edge.
- States: IDLE, UP_ACK, DOWN_ACK. Illegal encoding -> IDLE next edge.
- IDLE, up=1 & down=0: counter <= counter+step; state -> UP_ACK. upAck rises 1 cycle after the accepting edge.
- IDLE, down=1 & up=0: counter <= counter-step; state -> DOWN_ACK.
- IDLE, up=1 & down=1: no count; error <= 1; stay IDLE. Repeats each cycle while both are high.
- UP_ACK: hold upAck until up=0 sampled, then -> IDLE. Minimum ack length 1 cycle. DOWN_ACK is symmetric on down.
- Requests on the opposite line while in an ACK state are ignored until IDLE.
- Arithmetic is computed in SIZE+1 bits.
  - Wrap mode: result mod 2^SIZE; overflow/underflow pulse on carry/borrow.
  - Saturate mode: result clamped to 2^SIZE-1 or 0; overflow/underflow pulse only when clamping discards value.
  - Exact landing on a bound raises no flag.
- step=0: handshake completes normally; counter unchanged; no flags.
- load (below reset, above counting): counter <= data on that edge. State is not changed, so a pending ACK completes normally. A request arriving with load in IDLE is not accepted that cycle (no count, no state change); it is accepted on the first edge with load=0.
- overflow/underflow are registered, high exactly on the cycle after the counting edge, and never both high.
- Latency: request sampled at edge N -> counter and ack visible after edge N.

Optional Feature:
Macro UPDOWN_STEP_COUNTER_MATCH_EN.
- Defined: adds input matchValue (SIZE) and output match (1). match is registered and equals (counter == matchValue) evaluated on the post-update counter value; it is 0 during reset.
- Undefined: neither port exists; no compare logic is synthesised.

Test Plan:
- Reset with RESET_VALUE=8'h10 -> counter=8'h10, all flags 0; assert reset during UP_ACK -> IDLE next edge, upAck=0.
- SATURATE=0, counter=8'hFE, step=4'h3, up handshake -> counter=8'h01, overflow pulse 1 cycle, upAck held until up drops, then IDLE.
- SATURATE=1, counter=8'h02, step=4'h5, down -> counter=8'h00, underflow=1; repeat with counter=8'h05 -> 8'h00, no underflow.
- up and down both high in IDLE for 3 cycles -> counter unchanged, error=1 and stays 1 after both drop, cleared only by reset.
- load=1, data=8'hA5 with up=1 in IDLE -> counter=8'hA5, no ack; next edge load=0 -> counter=8'hA5+step, upAck=1. load during DOWN_ACK -> counter=data, downAck still held.
- MATCH_EN defined, matchValue=8'h07, counter=8'h04, step=3, up -> match=1 on the cycle counter reads 8'h07; step=0 handshake -> match stays 1.
